// File: rtl/usb_pkg.sv
// Shared USB definitions: access-size encodings, endpoint buffer geometry and
// the PID values used by usb_rx and usb_tx.
package usb_pkg;

  localparam int unsigned USB_BUF_DEPTH  = 64;
  localparam int unsigned USB_BUF_ADDR_W = 6;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Byte count of an AHB access; the reserved encoding moves nothing.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usb_buffer_mem.sv
// Byte-wide register file with a 1..4-byte write port and a 4-byte read window,
// both addressed modulo DEPTH so accesses may straddle the top of the array.
module usb_buffer_mem
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH  = USB_BUF_DEPTH,
  parameter int unsigned ADDR_W = USB_BUF_ADDR_W
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [2:0]        wcount_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [7:0]        mem_q   [DEPTH];
  logic [7:0]        mem_d   [DEPTH];
  logic [ADDR_W-1:0] waddr_k [4];
  logic [ADDR_W-1:0] raddr_k [4];

  for (genvar g = 0; g < 4; g++) begin : gen_lane
    assign waddr_k[g]         = waddr_i + ADDR_W'(g);
    assign raddr_k[g]         = raddr_i + ADDR_W'(g);
    assign rdata_o[8*g +: 8]  = mem_q[raddr_k[g]];
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 4; k++) begin
      if (wcount_i > 3'(k)) begin
        mem_d[waddr_k[k]] = wdata_i[8*k +: 8];
      end
    end
  end

  // Contents are deliberately not reset; occupancy gates every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/usb_data_buffer.sv
// Endpoint byte FIFO between usb_rx/usb_tx and the AHB slave: one push source and
// one pop source per cycle, multi-byte AHB accesses, flush/clear to empty.
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH  = USB_BUF_DEPTH,
  parameter int unsigned ADDR_W = USB_BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              clear,
  input  logic              store_rx_packet_data,
  input  logic [7:0]        rx_packet_data,
  input  logic              get_rx_data,
  input  logic              store_tx_data,
  input  logic [1:0]        data_size,
  input  logic [31:0]       tx_data,
  output logic [31:0]       rx_data,
  input  logic              get_tx_packet_data,
  output logic [7:0]        tx_packet_data,
  output logic [ADDR_W:0]   buffer_occupancy
);

  localparam int unsigned CntW = ADDR_W + 1;

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   occ_q, occ_d;

  logic [2:0]  push_size, pop_size, push_cnt, pop_cnt, rx_size;
  logic [31:0] push_data, win;

  always_comb begin
    push_size = '0;
    push_data = '0;
    if (store_rx_packet_data) begin
      push_size = 3'd1;
      push_data = {24'h0, rx_packet_data};
    end else if (store_tx_data) begin
      push_size = size_bytes(data_size);
      push_data = tx_data;
    end

    pop_size = '0;
    if (get_tx_packet_data) begin
      pop_size = 3'd1;
    end else if (get_rx_data) begin
      pop_size = size_bytes(data_size);
    end

    // Both checks use pre-edge occupancy, so a pop never consumes same-cycle pushes.
    push_cnt = (occ_q + CntW'(push_size) <= CntW'(DEPTH)) ? push_size : '0;
    pop_cnt  = (occ_q >= CntW'(pop_size)) ? pop_size : '0;

    wr_ptr_d = wr_ptr_q + ADDR_W'(push_cnt);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop_cnt);
    occ_d    = occ_q + CntW'(push_cnt) - CntW'(pop_cnt);

    if (flush || clear) begin
      push_cnt = '0;
      pop_cnt  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  usb_buffer_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i    (clk),
    .waddr_i  (wr_ptr_q),
    .wcount_i (push_cnt),
    .wdata_i  (push_data),
    .raddr_i  (rd_ptr_q),
    .rdata_o  (win)
  );

  // Bytes beyond the access size or beyond the valid data read as zero.
  always_comb begin
    rx_size = size_bytes(data_size);
    rx_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (rx_size > 3'(k) && occ_q > CntW'(k)) begin
        rx_data[8*k +: 8] = win[8*k +: 8];
      end
    end
    tx_packet_data = (occ_q != '0) ? win[7:0] : 8'h00;
  end

  assign buffer_occupancy = occ_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed and randomized checks of usb_data_buffer against a byte-queue model.
module tb_usb_data_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        flush, clear;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        get_rx_data, store_tx_data;
  logic [1:0]  data_size;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;

  byte unsigned q[$];
  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .flush                (flush),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_rx_data          (get_rx_data),
    .store_tx_data        (store_tx_data),
    .data_size            (data_size),
    .tx_data              (tx_data),
    .rx_data              (rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy)
  );

  function automatic int sz(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [31:0] exp_rx;
    exp_rx = '0;
    for (int k = 0; k < sz(data_size) && k < q.size(); k++) exp_rx[8*k +: 8] = q[k];
    check("m_occ", 32'(buffer_occupancy), 32'(q.size()));
    check("m_tx", 32'(tx_packet_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    check("m_rx", rx_data, exp_rx);
  endtask

  task automatic model_step();
    int n, psz, pz;
    byte unsigned pb[4];
    if (flush || clear) begin
      q.delete();
      return;
    end
    n   = q.size();
    psz = 0;
    pz  = 0;
    if (store_rx_packet_data) begin
      psz = 1;
      pb[0] = rx_packet_data;
    end else if (store_tx_data) begin
      psz = sz(data_size);
      for (int k = 0; k < 4; k++) pb[k] = tx_data[8*k +: 8];
    end
    if (get_tx_packet_data) pz = 1;
    else if (get_rx_data) pz = sz(data_size);
    if (n >= pz) repeat (pz) void'(q.pop_front());
    if (n + psz <= 64) for (int k = 0; k < psz; k++) q.push_back(pb[k]);
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    flush = 0; clear = 0; store_rx_packet_data = 0; get_rx_data = 0;
    store_tx_data = 0; get_tx_packet_data = 0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    idle();
    store_rx_packet_data = 1;
    rx_packet_data = b;
    cycle();
    idle();
  endtask

  task automatic tx_pop();
    idle();
    get_tx_packet_data = 1;
    cycle();
    idle();
  endtask

  initial begin
    n_rst = 0;
    idle();
    rx_packet_data = '0;
    data_size = 2'd0;
    tx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", 32'(buffer_occupancy), 32'd0);
    check("rst_rx", rx_data, 32'h0);
    check("rst_tx", 32'(tx_packet_data), 32'h0);
    @(negedge clk) n_rst = 1;
    @(posedge clk);
    #1;

    // Three bytes in, then a 2-byte read and a rejected 4-byte read.
    for (int i = 0; i < 3; i++) begin
      rx_push(8'(i));
      check("occ_fill3", 32'(buffer_occupancy), 32'(i + 1));
    end
    get_rx_data = 1; data_size = 2'd1;
    #1 check("rx_half", rx_data, 32'h0000_0100);
    cycle(); idle();
    check("occ_after_half", 32'(buffer_occupancy), 32'd1);
    get_rx_data = 1; data_size = 2'd2;
    #1 check("rx_word_short", rx_data, 32'h0000_0002);
    cycle(); idle();
    check("occ_word_rej", 32'(buffer_occupancy), 32'd1);
    clear = 1; cycle(); idle();
    check("occ_clear", 32'(buffer_occupancy), 32'd0);

    // Fill to capacity, overflow drop, then drain through the tx port.
    data_size = 2'd0;
    for (int i = 0; i < 64; i++) rx_push(8'(i));
    check("occ_full", 32'(buffer_occupancy), 32'd64);
    rx_push(8'hFF);
    check("occ_overflow", 32'(buffer_occupancy), 32'd64);
    check("tx_head_full", 32'(tx_packet_data), 32'h0);
    for (int i = 0; i < 64; i++) begin
      get_tx_packet_data = 1;
      #1 check("tx_drain", 32'(tx_packet_data), 32'(i));
      cycle(); idle();
    end
    check("occ_drained", 32'(buffer_occupancy), 32'd0);

    // Move both pointers to 62, then a word write/read straddling the wrap.
    for (int i = 0; i < 62; i++) rx_push(8'(i + 100));
    for (int i = 0; i < 62; i++) tx_pop();
    store_tx_data = 1; data_size = 2'd2; tx_data = 32'hDDCC_BBAA;
    cycle(); idle();
    check("occ_wrap", 32'(buffer_occupancy), 32'd4);
    get_rx_data = 1;
    #1 check("rx_wrap", rx_data, 32'hDDCC_BBAA);
    cycle(); idle();
    check("occ_wrap_pop", 32'(buffer_occupancy), 32'd0);

    // Flush wins over a simultaneous push and pop.
    for (int i = 0; i < 10; i++) rx_push(8'(i + 8'h30));
    check("occ_10", 32'(buffer_occupancy), 32'd10);
    flush = 1; store_rx_packet_data = 1; rx_packet_data = 8'h77; get_rx_data = 1;
    data_size = 2'd2;
    cycle(); idle();
    check("occ_flush", 32'(buffer_occupancy), 32'd0);
    check("rx_flush", rx_data, 32'h0);
    rx_push(8'h5A);
    check("tx_after_flush", 32'(tx_packet_data), 32'h5A);
    clear = 1; cycle(); idle();

    // Same-cycle push and word pop: the pushed byte lands behind the old data.
    for (int i = 0; i < 5; i++) rx_push(8'(8'hA0 + i));
    store_rx_packet_data = 1; rx_packet_data = 8'h55; get_rx_data = 1; data_size = 2'd2;
    #1 check("rx_simul", rx_data, 32'hA3A2_A1A0);
    cycle(); idle();
    check("occ_simul", 32'(buffer_occupancy), 32'd2);
    data_size = 2'd1;
    #1 check("rx_tail", rx_data, 32'h0000_55A4);
    data_size = 2'd3;
    #1 check("rx_reserved", rx_data, 32'h0);
    clear = 1; cycle(); idle();

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 20; i++) rx_push(8'(i));
    check("occ_20", 32'(buffer_occupancy), 32'd20);
    #2 n_rst = 0;
    #1 check("occ_async_rst", 32'(buffer_occupancy), 32'd0);
    q.delete();
    @(negedge clk) n_rst = 1;
    @(posedge clk);
    #1;
    check("tx_after_rst", 32'(tx_packet_data), 32'h0);

    // Random traffic: a push-heavy phase then a pop-heavy phase.
    for (int i = 0; i < 800; i++) begin
      idle();
      flush = ($urandom_range(0, 79) == 0);
      clear = ($urandom_range(0, 79) == 0);
      if (i < 400) begin
        store_rx_packet_data = ($urandom_range(0, 1) == 0);
        store_tx_data        = ($urandom_range(0, 1) == 0);
        get_tx_packet_data   = ($urandom_range(0, 5) == 0);
        get_rx_data          = ($urandom_range(0, 5) == 0);
      end else begin
        store_rx_packet_data = ($urandom_range(0, 4) == 0);
        store_tx_data        = ($urandom_range(0, 4) == 0);
        get_tx_packet_data   = ($urandom_range(0, 2) == 0);
        get_rx_data          = ($urandom_range(0, 1) == 0);
      end
      data_size      = 2'($urandom_range(0, 3));
      rx_packet_data = 8'($urandom);
      tx_data        = $urandom;
      cycle();
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
